// File: rtl/ks_add_arbiter.sv
// ks_add_arbiter: round-robin arbiter sharing one 32-bit Kogge-Stone adder among NREQ requesters.
module ks_add_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_sum,
    output logic                 rsp_cout,
    output logic [ID_W-1:0]      rsp_id
);
    logic [ID_W-1:0] r_ptr;
    logic            r_valid;
    logic [31:0]     r_sum;
    logic            r_cout;
    logic [ID_W-1:0] r_id;
    logic [ID_W-1:0] w_grant;
    logic            w_found;
    logic            w_issue;
    logic [31:0]     w_a;
    logic [31:0]     w_b;
    logic [31:0]     w_g [6];
    logic [31:0]     w_p [6];
    logic [31:0]     w_sum;
    logic            w_cout;

    // First valid requester at or after the pointer, wrapping modulo NREQ
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (int'(r_ptr) + k) % NREQ;
            if (!w_found && req_valid[j]) begin
                w_grant = ID_W'(j);
                w_found = 1'b1;
            end
        end
    end

    assign w_issue   = !rst && (!r_valid || rsp_ready) && (|req_valid);
    assign req_ready = w_issue ? (NREQ'(1) << w_grant) : '0;
    assign w_a       = req_a[32*w_grant +: 32];
    assign w_b       = req_b[32*w_grant +: 32];

    // Kogge-Stone prefix tree; with no carry-in, bits shifted in below 0 never propagate
    always_comb begin
        w_g[0] = w_a & w_b;
        w_p[0] = w_a ^ w_b;
        for (int l = 1; l < 6; l++) begin
            w_g[l] = w_g[l-1] | (w_p[l-1] & (w_g[l-1] << (1 << (l-1))));
            w_p[l] = w_p[l-1] & (w_p[l-1] << (1 << (l-1)));
        end
        w_sum  = w_p[0] ^ {w_g[5][30:0], 1'b0};
        w_cout = w_g[5][31];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_id    <= '0;
            r_ptr   <= '0;
        end else if (w_issue) begin
            r_valid <= 1'b1;
            r_sum   <= w_sum;
            r_cout  <= w_cout;
            r_id    <= w_grant;
            r_ptr   <= (w_grant == ID_W'(NREQ-1)) ? '0 : w_grant + 1'b1;
        end else if (rsp_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_valid;
    assign rsp_sum   = r_sum;
    assign rsp_cout  = r_cout;
    assign rsp_id    = r_id;
endmodule

// File: tb/tb_ks_add_arbiter.sv
// tb_ks_add_arbiter: directed vector table plus hand sequences for ks_add_arbiter.
module tb_ks_add_arbiter;
    localparam int NREQ = 4;
    localparam int ID_W = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic [NREQ-1:0]    req_ready;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [31:0]        rsp_sum;
    logic               rsp_cout;
    logic [ID_W-1:0]    rsp_id;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic        rr;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  er;
        logic        ev;
    } vec_t;

    vec_t        tv[$];
    logic [31:0] m_sum;
    logic        m_cout;
    logic [1:0]  m_id;

    always #5 clk = ~clk;

    ks_add_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] op_a(input logic [31:0] a, input int i);
        return a + 32'(i) * 32'h0001_0000;
    endfunction

    function automatic logic [31:0] op_b(input logic [31:0] b, input int i);
        return b + 32'(i);
    endfunction

    task automatic drive_one(input int idx, input logic [31:0] a, input logic [31:0] b);
        req_valid = 4'b0001 << idx;
        req_a = '0;
        req_b = '0;
        req_a[32*idx +: 32] = a;
        req_b[32*idx +: 32] = b;
    endtask

    task automatic add(input logic r, input logic [3:0] v, input logic rr, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] er, input logic ev);
        vec_t x;
        x.rst = r; x.v = v; x.rr = rr; x.a = a; x.b = b; x.er = er; x.ev = ev;
        tv.push_back(x);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", 32'(req_ready), 32'h0);
        chk("reset_valid", 32'(rsp_valid), 32'h0);
        chk("reset_sum", rsp_sum, 32'h0);
        chk("reset_cout", 32'(rsp_cout), 32'h0);
        chk("reset_id", 32'(rsp_id), 32'h0);

        @(negedge clk);
        rst = 1'b0;
        drive_one(0, 32'h3a6f36e3, 32'hf6af8732);
        #1 chk("single_ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        chk("single_valid", 32'(rsp_valid), 32'h1);
        chk("single_sum", rsp_sum, 32'h311ebe15);
        chk("single_cout", 32'(rsp_cout), 32'h1);
        chk("single_id", 32'(rsp_id), 32'h0);

        @(negedge clk);
        drive_one(2, 32'hffffffff, 32'h00000001);
        #1 chk("wrap_ready", 32'(req_ready), 32'h4);
        @(posedge clk); #1;
        chk("wrap_valid", 32'(rsp_valid), 32'h1);
        chk("wrap_sum", rsp_sum, 32'h0);
        chk("wrap_cout", 32'(rsp_cout), 32'h1);
        chk("wrap_id", 32'(rsp_id), 32'h2);

        @(negedge clk);
        drive_one(2, 32'h0, 32'h0);
        @(posedge clk); #1;
        chk("zero_sum", rsp_sum, 32'h0);
        chk("zero_cout", 32'(rsp_cout), 32'h0);
        chk("zero_id", 32'(rsp_id), 32'h2);

        // reset, round-robin 0..3,0..3, then only 1 and 3 valid
        add(1, 4'hf, 1, 32'h12345678, 32'h9abcdef0, 4'b0000, 0);
        add(0, 4'hf, 1, 32'h80000000, 32'h80000000, 4'b0001, 1);
        add(0, 4'hf, 1, 32'h0fff0000, 32'hf0010000, 4'b0010, 1);
        add(0, 4'hf, 1, 32'hdeadbeef, 32'h21524110, 4'b0100, 1);
        add(0, 4'hf, 1, 32'h7fffffff, 32'h00000001, 4'b1000, 1);
        add(0, 4'hf, 1, 32'h55555555, 32'haaaaaaab, 4'b0001, 1);
        add(0, 4'hf, 1, 32'h00ff00ff, 32'hff00ff00, 4'b0010, 1);
        add(0, 4'hf, 1, 32'hcafef00d, 32'h13572468, 4'b0100, 1);
        add(0, 4'hf, 1, 32'h01234567, 32'h89abcdef, 4'b1000, 1);
        add(0, 4'ha, 1, 32'hfffe0000, 32'h00020000, 4'b0010, 1);
        add(0, 4'ha, 1, 32'h11111111, 32'h22222222, 4'b1000, 1);
        add(0, 4'ha, 1, 32'hf0f0f0f0, 32'h0f0f0f10, 4'b0010, 1);
        add(0, 4'ha, 1, 32'h00000003, 32'hfffffffd, 4'b1000, 1);
        // backpressure: five stalled cycles, then drain plus issue together
        for (int i = 0; i < 5; i++) add(0, 4'hf, 0, 32'h9999_0000 + 32'(i), 32'h7777_0000, 4'b0000, 1);
        add(0, 4'hf, 1, 32'hbeef0000, 32'h4111ffff, 4'b0001, 1);
        // drain to idle; idle cycles leave the pointer at requester 1
        add(0, 4'h0, 1, 32'h0, 32'h0, 4'b0000, 0);
        add(0, 4'h0, 1, 32'h0, 32'h0, 4'b0000, 0);
        add(0, 4'h0, 1, 32'h0, 32'h0, 4'b0000, 0);
        add(0, 4'hf, 1, 32'h87654321, 32'h789abcdf, 4'b0010, 1);
        add(0, 4'hf, 1, 32'h31415926, 32'h27182818, 4'b0100, 1);
        // reset mid-stream, then restart at requester 0
        add(1, 4'hf, 1, 32'h44444444, 32'h44444444, 4'b0000, 0);
        add(0, 4'hf, 1, 32'hffff0000, 32'h0001ffff, 4'b0001, 1);
        add(0, 4'hf, 1, 32'h00010001, 32'h80008000, 4'b0010, 1);

        m_sum = rsp_sum;
        m_cout = rsp_cout;
        m_id = 2'd2;
        for (int n = 0; n < tv.size(); n++) begin
            @(negedge clk);
            rst = tv[n].rst;
            req_valid = tv[n].v;
            rsp_ready = tv[n].rr;
            for (int i = 0; i < NREQ; i++) begin
                req_a[32*i +: 32] = op_a(tv[n].a, i);
                req_b[32*i +: 32] = op_b(tv[n].b, i);
            end
            #1 chk($sformatf("v%0d_ready", n), 32'(req_ready), 32'(tv[n].er));
            @(posedge clk);
            if (tv[n].rst) begin
                m_sum = '0; m_cout = 1'b0; m_id = '0;
            end else if (tv[n].er != 4'b0000) begin
                for (int i = 0; i < NREQ; i++)
                    if (tv[n].er[i]) m_id = 2'(i);
                {m_cout, m_sum} = 33'(op_a(tv[n].a, int'(m_id))) + 33'(op_b(tv[n].b, int'(m_id)));
            end
            #1;
            chk($sformatf("v%0d_valid", n), 32'(rsp_valid), 32'(tv[n].ev));
            chk($sformatf("v%0d_sum", n), rsp_sum, m_sum);
            chk($sformatf("v%0d_cout", n), 32'(rsp_cout), 32'(m_cout));
            chk($sformatf("v%0d_id", n), 32'(rsp_id), 32'(m_id));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ks_add_arbiter.md
# ks_add_arbiter

Round-robin arbiter and sequencer that shares one 32-bit Kogge-Stone adder datapath (level0 → level5 prefix tree plus the ksadder sum stage) among NREQ independent requesters. Each requester presents an operand pair under a valid/ready handshake. The block grants one requester per cycle, registers the sum, carry-out and requester ID, and holds the result in a one-entry output register until the consumer accepts it. It sits between the operand-producing units and the shared adder, so requesters never instantiate adders of their own.

## Interface

Parameters
- NREQ, 4, number of requesters; legal range 2..8.
- ID_W, 2, width of the requester ID; must equal ceil(log2(NREQ)).

Ports
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  bit i high: requester i presents operands.
- req_a  input  NREQ*32  operand A; requester i occupies bits [32i+31:32i].
- req_b  input  NREQ*32  operand B; same packing as req_a.
- req_ready  output  NREQ  one-hot or zero; bit i high: requester i's operands are accepted on this edge.
- rsp_valid  output  1  result register holds a valid result.
- rsp_ready  input  1  consumer accepts the result on this edge.
- rsp_sum  output  32  (A+B) mod 2^32.
- rsp_cout  output  1  carry-out, i.e. bit 32 of A+B.
- rsp_id  output  ID_W  index of the requester that produced the result.

## Operation

- Datapath: one internal instance of the team's 32-bit KS adder chain, with no carry-in. The operand mux selects req_a/req_b of the granted requester. The adder is purely combinational; the only sequential element is the output register.
- Issue condition: issue = (!rsp_valid || rsp_ready) && (|req_valid).
- Arbitration: a round-robin pointer ptr (ID_W bits, range 0..NREQ-1).
  - The grant goes to the first i with req_valid[i] set, searching ptr, ptr+1, … modulo NREQ.
  - req_ready[grant] = issue. All other bits are 0.
  - req_ready depends combinationally on req_valid, rsp_valid and rsp_ready.
- On an issue edge:
  - rsp_sum, rsp_cout and rsp_id load the granted requester's result.
  - rsp_valid becomes 1.
  - ptr becomes grant+1 modulo NREQ. The wrap is from NREQ-1 to 0.
- On an edge with rsp_valid && rsp_ready and no issue:
  - rsp_valid becomes 0.
  - rsp_sum, rsp_cout and rsp_id keep their last values.
- Simultaneous drain and issue: the new result overwrites the old one and rsp_valid stays 1. This gives full throughput.
- Backpressure: while rsp_valid && !rsp_ready, every req_ready bit is 0. The register and ptr hold.
- Requesters must keep req_valid, req_a and req_b stable until they see req_ready. The arbiter does not latch operands before the grant.
- ptr changes only on issue. Idle cycles do not move it.
- States are implicit in rsp_valid:
  - EMPTY (rsp_valid=0) goes to FULL on issue.
  - FULL goes to EMPTY on drain without issue.
  - FULL stays FULL on stall, or on drain together with issue.

## Timing

- Reset (rst high at an edge): rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, ptr=0. req_ready is 0 for the whole cycle that rst is high.
- Reset mid-operation: a pending result is discarded with no response. An operand accepted in the same cycle as rst is lost; the requester treats it as never accepted.
- Latency: a request is accepted at edge k, and rsp_valid is high with the result after edge k.
- Throughput: one result per cycle while rsp_ready=1 and any req_valid is high.
- Fairness: with all requesters continuously valid and rsp_ready=1, each requester is granted exactly once in every NREQ consecutive cycles.
- The combinational path req_a/req_b → mux → KS tree → output register must close timing in one cycle.

## Test plan

- **Single add:** reset, then req_valid=4'b0001, req_a[0]=32'h3a6f36e3, req_b[0]=32'hf6af8732.
  - Required: req_ready=4'b0001 in that cycle.
  - Next cycle: rsp_valid=1, rsp_sum=32'h311ebe15, rsp_cout=1, rsp_id=0.
- **Wrap carry:** requester 2 presents 32'hffffffff + 32'h00000001.
  - Required: rsp_sum=0, rsp_cout=1, rsp_id=2.
  - Then 32'h00000000 + 32'h00000000 gives rsp_sum=0, rsp_cout=0.
- **Round-robin:** all four requesters valid continuously, rsp_ready=1.
  - Required: rsp_id sequence 0,1,2,3,0,1 on consecutive cycles, each rsp_sum matching its operands.
  - With only requesters 1 and 3 valid: 1,3,1,3.
- **Backpressure:** result pending with rsp_ready=0 for 5 cycles while requesters 0..3 are valid.
  - Required: req_ready=0, and rsp_sum/rsp_id stable for all 5 cycles.
  - Raising rsp_ready gives a drain plus new issue in the same cycle, and rsp_valid stays 1.
- **Drain to idle:** one result, rsp_ready=1, no further req_valid.
  - Required: rsp_valid falls one cycle after the result appears; rsp_sum holds its value; ptr is unchanged by the idle cycles.
- **Reset mid-stream:** during a continuous round-robin stream, assert rst for one cycle.
  - Required: next cycle rsp_valid=0, outputs are 0, req_ready=0 during rst.
  - The first grant after reset goes to requester 0.
